muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the M-extension operations decoded by the ALU selector: MUL (code 7), MULH (8), DIV (9), REM (10).
- Sits beside the execute-stage ALU. It accepts one operation, holds the pipeline through a stall output, iterates a shared shift-add/shift-subtract datapath, and returns a single-cycle result strobe.
- Branch flush kills an in-flight operation.

---
 rtl/muldiv_sequencer_if.sv | 14 +
 rtl/muldiv_sequencer.sv | 121 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, alu_sel, op_a, op_b, flush, input stall, done, result);
  modport slave  (input start, alu_sel, op_a, op_b, flush, output stall, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed MUL/MULH/DIV/REM unit sharing one shift-add / restoring shift-subtract datapath.
// Holds the pipeline via stall and returns a one-cycle done strobe with a held result.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;     // 0 MUL, 1 MULH, 2 DIV, 3 REM
  logic            r_sa, r_sb;
  logic [XLEN-1:0] r_hi, r_lo, r_m;
  logic [XLEN-1:0] r_result;

  logic            w_sel_ok, w_is_div, w_accept, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic [XLEN:0]   w_sum, w_sh, w_dif;
  logic            w_qbit;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_quo, w_rem, w_fix;

  assign w_sel_ok  = (bus.alu_sel >= 4'd7) && (bus.alu_sel <= 4'd10);
  assign w_is_div  = (bus.alu_sel == 4'd9) || (bus.alu_sel == 4'd10);
  assign w_accept  = (r_state == S_IDLE) && bus.start && w_sel_ok && !bus.flush;
  assign w_abs_a   = bus.op_a[XLEN-1] ? (XLEN'(0) - bus.op_a) : bus.op_a;
  assign w_abs_b   = bus.op_b[XLEN-1] ? (XLEN'(0) - bus.op_b) : bus.op_b;
  assign w_div0    = (bus.op_b == '0);
  assign w_ovf     = (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  assign w_special = w_is_div && (w_div0 || w_ovf);

  // Multiply step: conditionally add multiplicand into the high half, then shift the pair right.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  // Divide step: shift next dividend bit into the partial remainder, keep the difference if no borrow.
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_dif  = w_sh - {1'b0, r_m};
  assign w_qbit = ~w_dif[XLEN];

  assign w_prod_s = (r_sa ^ r_sb) ? ((2*XLEN)'(0) - {r_hi, r_lo}) : {r_hi, r_lo};
  assign w_quo    = (r_sa ^ r_sb) ? (XLEN'(0) - r_lo) : r_lo;
  assign w_rem    = r_sa ? (XLEN'(0) - r_hi) : r_hi;

  always_comb begin
    w_fix = '0;
    case (r_op)
      2'd0:    w_fix = w_prod_s[XLEN-1:0];
      2'd1:    w_fix = w_prod_s[2*XLEN-1:XLEN];
      2'd2:    w_fix = w_quo;
      default: w_fix = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= bus.alu_sel[1:0] + 2'd1;
          r_cnt <= '0;
          if (w_special) begin
            // Quotient/remainder preloaded in final form; clearing signs bypasses correction.
            r_state <= S_FIX;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_lo    <= w_div0 ? '1 : bus.op_a;
            r_hi    <= w_div0 ? bus.op_a : '0;
          end else begin
            r_state <= S_RUN;
            r_sa    <= bus.op_a[XLEN-1];
            r_sb    <= bus.op_b[XLEN-1];
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_abs_a : w_abs_b;
            r_m     <= w_is_div ? w_abs_b : w_abs_a;
          end
        end
        S_RUN: begin
          if (!r_op[1]) begin
            {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
          end else begin
            r_hi <= w_qbit ? w_dif[XLEN-1:0] : w_sh[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_qbit};
          end
          if (r_cnt == CW'(XLEN-1)) begin
            r_state <= S_FIX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_result <= w_fix;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall  = !bus.flush && (w_accept || r_state == S_RUN || r_state == S_FIX);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected result and done cycle, a negedge monitor pops on done.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  muldiv_sequencer_if #(.XLEN(XLEN)) mif ();
  muldiv_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(mif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && mif.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(mif.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", mif.result, e.res);
        chk("done_latency", 32'(cyc), 32'(e.cyc));
        chk("stall_in_done", 32'(mif.stall), 32'd0);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_waiting_done", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [3:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input bit special);
    exp_t e;
    @(negedge clk);
    mif.start = 1'b1; mif.alu_sel = sel; mif.op_a = a; mif.op_b = b;
    #1 chk("stall_on_accept", 32'(mif.stall), 32'd1);
    e.res = exp;
    e.cyc = cyc + 1 + (special ? 1 : XLEN + 1);
    sb.push_back(e);
    @(negedge clk);
    mif.start = 1'b0; mif.alu_sel = 4'd0; mif.op_a = 32'hDEAD_BEEF; mif.op_b = 32'h1234_5678;
    #1 chk("stall_busy", 32'(mif.stall), 32'd1);
    drain();
  endtask

  initial begin
    mif.start = 1'b0; mif.alu_sel = 4'd0; mif.op_a = '0; mif.op_b = '0; mif.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(mif.done), 32'd0);
    chk("reset_stall", 32'(mif.stall), 32'd0);
    chk("reset_result", mif.result, 32'd0);
    rst = 1'b0;

    issue(4'd7,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    issue(4'd8,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    issue(4'd8,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0);
    issue(4'd7,  32'h1234_5678, 32'h10,       32'h2345_6780, 1'b0);
    issue(4'd9,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
    issue(4'd10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
    issue(4'd10, 32'd7,        32'hFFFF_FFFE, 32'd1,        1'b0);
    issue(4'd9,  32'd100,      32'd7,        32'd14,       1'b0);
    issue(4'd10, 32'd100,      32'd7,        32'd2,        1'b0);
    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1'b1);
    issue(4'd9,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(4'd10, 32'd5,        32'd0,        32'd5,        1'b1);
    issue(4'd9,  32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);

    // Flush a running DIV: no done, stall drops, result register untouched.
    @(negedge clk);
    mif.start = 1'b1; mif.alu_sel = 4'd9; mif.op_a = 32'd1000; mif.op_b = 32'd3;
    @(negedge clk);
    mif.start = 1'b0; mif.alu_sel = 4'd0;
    repeat (8) @(negedge clk);
    mif.flush = 1'b1;
    #1 chk("stall_in_flush", 32'(mif.stall), 32'd0);
    @(negedge clk);
    mif.flush = 1'b0;
    #1 chk("stall_after_flush", 32'(mif.stall), 32'd0);
    chk("done_after_flush", 32'(mif.done), 32'd0);
    chk("result_kept_after_flush", mif.result, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    chk("result_kept_later", mif.result, 32'hFFFF_FFFF);
    issue(4'd7, 32'd3, 32'd4, 32'd12, 1'b0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    mif.start = 1'b1; mif.alu_sel = 4'd9; mif.op_a = 32'd77; mif.op_b = 32'd5;
    @(negedge clk);
    mif.start = 1'b0; mif.alu_sel = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_result", mif.result, 32'd0);
    chk("rst_mid_done", 32'(mif.done), 32'd0);
    chk("rst_mid_stall", 32'(mif.stall), 32'd0);
    mif.start = 1'b1; mif.alu_sel = 4'd2; mif.op_a = 32'd9; mif.op_b = 32'd9;
    #1 chk("non_md_sel_stall", 32'(mif.stall), 32'd0);
    repeat (40) @(negedge clk);
    #1 chk("non_md_sel_stall_late", 32'(mif.stall), 32'd0);
    chk("non_md_sel_result", mif.result, 32'd0);
    mif.start = 1'b0;

    // Flush and start together in IDLE: not accepted.
    @(negedge clk);
    mif.start = 1'b1; mif.alu_sel = 4'd7; mif.op_a = 32'd2; mif.op_b = 32'd2; mif.flush = 1'b1;
    #1 chk("flush_start_stall", 32'(mif.stall), 32'd0);
    @(negedge clk);
    mif.start = 1'b0; mif.flush = 1'b0;
    #1 chk("flush_start_not_accepted", 32'(mif.stall), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_start_result", mif.result, 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
